// File: rtl/bell_pkg.sv
// bell_pkg: shared definitions for the bell-slap round judge.
//   - bell_state_e : judge FSM state encoding
//   - DEF_TARGET / DEF_MARGIN : default colour target and winning lead
//   - sat_add : signed add clamped to a w-bit two's-complement range
package bell_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_JUDGE = 2'd2,
    S_OVER  = 2'd3
  } bell_state_e;

  localparam int DEF_TARGET = 5;
  localparam int DEF_MARGIN = 50;

  // Operands are pre-extended to 32 bits, so the raw sum cannot wrap for any
  // practical score width; the result is clamped to [-2^(w-1), 2^(w-1)-1].
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sum > hi) begin
      sat_add = hi;
    end else if (sum < lo) begin
      sat_add = lo;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/bell_round_judge_if.sv
// bell_round_judge_if: bundles the card/press inputs and the judge/score
// outputs of bell_round_judge.
//   master : keypad/card side (drives round_start, card_*, pot, press)
//   slave  : the judge (drives armed, judge_*, score, game_over, win_player)
interface bell_round_judge_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int NUM_COLORS  = 4,
  parameter int COUNT_W     = 3,
  parameter int SCORE_W     = 9
);
  localparam int CW = $clog2(NUM_COLORS);
  localparam int PW = $clog2(NUM_PLAYERS);

  logic                           round_start;
  logic [NUM_PLAYERS-1:0]         card_valid;
  logic [NUM_PLAYERS*CW-1:0]      card_color;
  logic [NUM_PLAYERS*COUNT_W-1:0] card_count;
  logic [7:0]                     pot;
  logic [NUM_PLAYERS-1:0]         press;
  logic                           armed;
  logic                           judge_valid;
  logic [PW-1:0]                  judge_who;
  logic                           judge_right;
  logic [NUM_PLAYERS*SCORE_W-1:0] score;
  logic                           game_over;
  logic [PW-1:0]                  win_player;

  modport master (
    output round_start, card_valid, card_color, card_count, pot, press,
    input  armed, judge_valid, judge_who, judge_right, score, game_over, win_player
  );

  modport slave (
    input  round_start, card_valid, card_color, card_count, pot, press,
    output armed, judge_valid, judge_who, judge_right, score, game_over, win_player
  );
endinterface

// File: rtl/bell_press_arbiter.sv
// bell_press_arbiter: bell press rising-edge detection and winner pick.
// Ports: clk, rst (sync, active-low), armed_i (round open), press_i (bell
// levels), hit_o (a counted edge this cycle), who_o (picked player).
// Macro BELL_RR_PRIORITY_EN selects round-robin instead of lowest-index pick.
module bell_press_arbiter #(
  parameter int NUM_PLAYERS = 4,
  parameter int PW          = $clog2(NUM_PLAYERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   armed_i,
  input  logic [NUM_PLAYERS-1:0] press_i,
  output logic                   hit_o,
  output logic [PW-1:0]          who_o
);

  logic [NUM_PLAYERS-1:0] press_q;
  logic [NUM_PLAYERS-1:0] rise_s;

  // Press history is kept in every state so a held press never looks new.
  always_ff @(posedge clk) begin
    if (!rst) begin
      press_q <= '0;
    end else begin
      press_q <= press_i;
    end
  end

  assign rise_s = press_i & ~press_q;
  assign hit_o  = armed_i & (|rise_s);

`ifdef BELL_RR_PRIORITY_EN
  logic [PW-1:0] ptr_q;
  logic          found_s;
  int            idx_s;

  // Round-robin pick: first rising press at or after the pointer.
  always_comb begin
    who_o   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      idx_s = (int'(ptr_q) + k) % NUM_PLAYERS;
      if (!found_s && rise_s[idx_s]) begin
        found_s = 1'b1;
        who_o   = PW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves past the last accepted presser.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (hit_o) begin
      ptr_q <= PW'((int'(who_o) + 1) % NUM_PLAYERS);
    end else begin
      ptr_q <= ptr_q;
    end
  end
`else
  // Fixed priority: scan downwards so the lowest rising index is kept.
  always_comb begin
    who_o = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      if (rise_s[k]) begin
        who_o = PW'(k);
      end else begin
        who_o = who_o;
      end
    end
  end
`endif

endmodule

// File: rtl/bell_round_judge.sv
// bell_round_judge: N-player bell-slap judge. Latches a round's cards,
// arbitrates the first bell press, decides right/wrong from colour totals,
// updates saturating signed scores and flags a winning margin.
// Ports: clk, rst (sync, active-low), bus (bell_round_judge_if.slave).
// Macro BELL_RR_PRIORITY_EN (in bell_press_arbiter) enables round-robin pick.
module bell_round_judge
  import bell_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int NUM_COLORS  = 4,
  parameter int COUNT_W     = 3,
  parameter int SCORE_W     = 9,
  parameter int TARGET      = DEF_TARGET,
  parameter int MARGIN      = DEF_MARGIN,
  parameter int PENALTY     = 1
) (
  input  logic               clk,
  input  logic               rst,
  bell_round_judge_if.slave  bus
);

  localparam int CW    = $clog2(NUM_COLORS);
  localparam int PW    = $clog2(NUM_PLAYERS);
  localparam int SUM_W = COUNT_W + PW;
  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_ARMED = S_ARMED;
  localparam logic [1:0] ST_JUDGE = S_JUDGE;
  localparam logic [1:0] ST_OVER  = S_OVER;
  localparam logic signed [31:0] LOSS = 32'(-((NUM_PLAYERS - 1) * PENALTY));
  localparam logic signed [31:0] GAIN = 32'(PENALTY);

  logic [1:0]                     state_q, state_d;
  logic [NUM_PLAYERS-1:0]         cvalid_q;
  logic [NUM_PLAYERS*CW-1:0]      ccolor_q;
  logic [NUM_PLAYERS*COUNT_W-1:0] ccount_q;
  logic [7:0]                     pot_q;
  logic                           armed_q, judge_valid_q, right_q, game_over_q;
  logic [PW-1:0]                  who_q, win_player_q;
  logic signed [SCORE_W-1:0]      score_q [NUM_PLAYERS];
  logic signed [SCORE_W-1:0]      score_d [NUM_PLAYERS];
  logic                           hit_s, right_s, win_hit_s, qual_s;
  logic [PW-1:0]                  who_s, win_idx_s;
  logic [SUM_W-1:0]               sum_s;
  logic signed [SCORE_W:0]        lead_s, other_s;

  bell_press_arbiter #(.NUM_PLAYERS(NUM_PLAYERS), .PW(PW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .armed_i (state_q == ST_ARMED),
    .press_i (bus.press),
    .hit_o   (hit_s),
    .who_o   (who_s)
  );

  // Per-colour totals of the latched cards; right if any total hits TARGET.
  always_comb begin
    right_s = 1'b0;
    sum_s   = '0;
    for (int c = 0; c < NUM_COLORS; c++) begin
      sum_s = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (cvalid_q[p] && (ccolor_q[p*CW +: CW] == CW'(c))) begin
          sum_s = sum_s + SUM_W'(ccount_q[p*COUNT_W +: COUNT_W]);
        end else begin
          sum_s = sum_s;
        end
      end
      if (sum_s == SUM_W'(TARGET)) begin
        right_s = 1'b1;
      end else begin
        right_s = right_s;
      end
    end
  end

  // Next scores: only the JUDGE cycle writes, using the registered verdict.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_d[i] = score_q[i];
      if (state_q == ST_JUDGE) begin
        if (right_q) begin
          if (PW'(i) == who_q) begin
            score_d[i] = SCORE_W'(sat_add(32'(score_q[i]), $signed({24'd0, pot_q}), SCORE_W));
          end else begin
            score_d[i] = score_q[i];
          end
        end else if (PW'(i) == who_q) begin
          score_d[i] = SCORE_W'(sat_add(32'(score_q[i]), LOSS, SCORE_W));
        end else begin
          score_d[i] = SCORE_W'(sat_add(32'(score_q[i]), GAIN, SCORE_W));
        end
      end else begin
        score_d[i] = score_q[i];
      end
    end
  end

  // Win check on the new scores, one bit wider so +MARGIN cannot wrap;
  // scanning downwards leaves the lowest qualifying index.
  always_comb begin
    win_hit_s = 1'b0;
    win_idx_s = '0;
    qual_s    = 1'b0;
    lead_s    = '0;
    other_s   = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      qual_s = 1'b1;
      lead_s = $signed({score_d[i][SCORE_W-1], score_d[i]});
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        other_s = $signed({score_d[j][SCORE_W-1], score_d[j]}) + (SCORE_W + 1)'(MARGIN);
        if ((j != i) && (lead_s < other_s)) begin
          qual_s = 1'b0;
        end else begin
          qual_s = qual_s;
        end
      end
      if (qual_s) begin
        win_hit_s = 1'b1;
        win_idx_s = PW'(i);
      end else begin
        win_hit_s = win_hit_s;
      end
    end
  end

  // Round FSM.
  always_comb begin
    case (state_q)
      ST_IDLE:  state_d = bus.round_start ? ST_ARMED : ST_IDLE;
      ST_ARMED: state_d = hit_s ? ST_JUDGE : ST_ARMED;
      ST_JUDGE: state_d = win_hit_s ? ST_OVER : ST_IDLE;
      ST_OVER:  state_d = ST_OVER;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, latched cards, verdict, score file and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cvalid_q      <= '0;
      ccolor_q      <= '0;
      ccount_q      <= '0;
      pot_q         <= 8'd0;
      armed_q       <= 1'b0;
      judge_valid_q <= 1'b0;
      right_q       <= 1'b0;
      who_q         <= '0;
      game_over_q   <= 1'b0;
      win_player_q  <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      armed_q       <= (state_d == ST_ARMED);
      judge_valid_q <= (state_d == ST_JUDGE);
      if ((state_q == ST_IDLE || state_q == ST_ARMED) && bus.round_start) begin
        cvalid_q <= bus.card_valid;
        ccolor_q <= bus.card_color;
        ccount_q <= bus.card_count;
      end
      if (state_q == ST_ARMED && hit_s) begin
        who_q   <= who_s;
        right_q <= right_s;
        pot_q   <= bus.pot;
      end
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= score_d[i];
      if (state_q == ST_JUDGE && win_hit_s) begin
        game_over_q  <= 1'b1;
        win_player_q <= win_idx_s;
      end
    end
  end

  // Drive the bus from registers only.
  always_comb begin
    bus.armed       = armed_q;
    bus.judge_valid = judge_valid_q;
    bus.judge_who   = who_q;
    bus.judge_right = right_q;
    bus.game_over   = game_over_q;
    bus.win_player  = win_player_q;
    bus.score       = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) bus.score[i*SCORE_W +: SCORE_W] = score_q[i];
  end

endmodule

// File: tb/tb_bell_round_judge.sv
module tb_bell_round_judge;
  localparam int N = 4, NC = 4, CNTW = 3, SW = 9, TGT = 5, MRG = 50, PEN = 1;
  localparam int SMAX = 255, SMIN = -256;

  typedef struct packed {
    logic [1:0]      who;
    logic            right;
    logic [N*SW-1:0] sc;
    logic            go;
    logic [1:0]      wp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bell_round_judge_if #(.NUM_PLAYERS(N), .NUM_COLORS(NC), .COUNT_W(CNTW), .SCORE_W(SW)) bus ();

  bell_round_judge #(.NUM_PLAYERS(N), .NUM_COLORS(NC), .COUNT_W(CNTW), .SCORE_W(SW),
                     .TARGET(TGT), .MARGIN(MRG), .PENALTY(PEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0, failures = 0;
  exp_t sb_q[$];
  int   m_sc[N];
  int   m_go = 0, m_wp = 0;
  logic [2*N-1:0]    t_col;
  logic [CNTW*N-1:0] t_cnt;
  logic [N-1:0]      t_vld;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_score(input int i);
    logic signed [SW-1:0] s;
    s = bus.score[i*SW +: SW];
    return int'(s);
  endfunction

  function automatic int clamp(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic bit model_right();
    int sum;
    bit r = 0;
    for (int c = 0; c < NC; c++) begin
      sum = 0;
      for (int p = 0; p < N; p++)
        if (t_vld[p] && int'(t_col[p*2 +: 2]) == c) sum += int'(t_cnt[p*CNTW +: CNTW]);
      if (sum == TGT) r = 1;
    end
    return r;
  endfunction

  task automatic set_cards(input logic [2*N-1:0] col, input logic [CNTW*N-1:0] cnt,
                           input logic [N-1:0] vld, input logic [7:0] pot);
    t_col = col; t_cnt = cnt; t_vld = vld;
    bus.card_color = col; bus.card_count = cnt; bus.card_valid = vld; bus.pot = pot;
  endtask

  // Model a judge by player 'who' and queue the expected outcome.
  task automatic push_expect(input int who);
    exp_t e;
    bit r, q;
    r = model_right();
    for (int i = 0; i < N; i++) begin
      if (r) begin
        if (i == who) m_sc[i] = clamp(m_sc[i] + int'(bus.pot));
      end else if (i == who) m_sc[i] = clamp(m_sc[i] - (N - 1) * PEN);
      else m_sc[i] = clamp(m_sc[i] + PEN);
    end
    for (int i = N - 1; i >= 0; i--) begin
      q = 1;
      for (int j = 0; j < N; j++) if (j != i && m_sc[i] < m_sc[j] + MRG) q = 0;
      if (q) begin m_go = 1; m_wp = i; end
    end
    e.who = 2'(who); e.right = r; e.go = 1'(m_go); e.wp = 2'(m_wp);
    for (int i = 0; i < N; i++) e.sc[i*SW +: SW] = SW'(m_sc[i]);
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < N; i++) m_sc[i] = 0;
    m_go = 0; m_wp = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_armed"}, int'(bus.armed), 0);
    chk({tag, "_jvalid"}, int'(bus.judge_valid), 0);
    chk({tag, "_who"}, int'(bus.judge_who), 0);
    chk({tag, "_right"}, int'(bus.judge_right), 0);
    chk({tag, "_gover"}, int'(bus.game_over), 0);
    chk({tag, "_wp"}, int'(bus.win_player), 0);
    for (int i = 0; i < N; i++) chk($sformatf("%s_score%0d", tag, i), dut_score(i), 0);
  endtask

  task automatic round_open(input bit expect_armed);
    @(posedge clk); #1 bus.round_start = 1'b1;
    @(posedge clk); #1 bus.round_start = 1'b0;
    @(negedge clk);
    chk("armed_after_start", int'(bus.armed), int'(expect_armed));
  endtask

  task automatic no_judge(input int cycles, input string tag);
    bit seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.judge_valid) seen = 1;
    end
    chk(tag, int'(seen), 0);
  endtask

  // Raise the press bits at a negedge, then check verdict (t+1) and scores (t+2).
  task automatic press_judge(input logic [N-1:0] mask, input int who, input bit release_after);
    exp_t e;
    int lat = -1;
    bus.press = bus.press | mask;
    push_expect(who);
    for (int k = 0; k < 4 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.judge_valid) lat = k;
    end
    e = sb_q.pop_front();
    chk("judge_latency", lat, 0);
    if (lat >= 0) begin
      chk("judge_who", int'(bus.judge_who), int'(e.who));
      chk("judge_right", int'(bus.judge_right), int'(e.right));
      chk("armed_in_judge", int'(bus.armed), 0);
      @(negedge clk);
      chk("judge_strobe_len", int'(bus.judge_valid), 0);
      for (int i = 0; i < N; i++)
        chk($sformatf("score%0d", i), dut_score(i), int'($signed(e.sc[i*SW +: SW])));
      chk("game_over", int'(bus.game_over), int'(e.go));
      if (e.go) chk("win_player", int'(bus.win_player), int'(e.wp));
    end
    if (release_after) bus.press = bus.press & ~mask;
  endtask

  initial begin
    bus.round_start = 1'b0; bus.press = '0;
    set_cards('0, '0, '0, 8'd0);
    for (int i = 0; i < N; i++) m_sc[i] = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;

    // Press while IDLE is ignored.
    @(negedge clk); bus.press = 4'b1000;
    no_judge(4, "idle_press");
    bus.press = '0;

    // Colour 0 sums to 5: right press by P2.
    set_cards(8'b10_01_00_00, 12'b100_001_011_010, 4'hF, 8'd6);
    round_open(1'b1);
    press_judge(4'b0100, 2, 1'b1);
    chk("t1_score2_lit", dut_score(2), 6);

    // Simultaneous edges on P1 and P3 after P2 won the previous judge.
    round_open(1'b1);
`ifdef BELL_RR_PRIORITY_EN
    press_judge(4'b1010, 3, 1'b1);
`else
    press_judge(4'b1010, 1, 1'b1);
`endif

    // No colour totals 5: wrong press by P1.
    do_reset();
    set_cards(8'b10_01_00_00, 12'b100_001_100_010, 4'hF, 8'd6);
    round_open(1'b1);
    press_judge(4'b0010, 1, 1'b1);
    chk("t2_score1_lit", dut_score(1), -3);
    chk("t2_score0_lit", dut_score(0), 1);

    // Held press spans two rounds: only the first round is judged.
    set_cards(8'b10_01_00_00, 12'b100_001_011_010, 4'hF, 8'd6);
    round_open(1'b1);
    press_judge(4'b0001, 0, 1'b0);
    round_open(1'b1);
    no_judge(5, "held_press");
    chk("held_still_armed", int'(bus.armed), 1);
    bus.press = '0;

    // Build scores evenly, then push P0 into saturation and a winning lead.
    do_reset();
    bus.pot = 8'd41;
    for (int r = 0; r < 5; r++)
      for (int p = 0; p < N; p++) begin
        round_open(1'b1);
        press_judge(N'(1) << p, p, 1'b1);
      end
    bus.pot = 8'd45;
    round_open(1'b1);
    press_judge(4'b0001, 0, 1'b1);
    chk("sat_pre_score0", dut_score(0), 250);
    bus.pot = 8'd10;
    round_open(1'b1);
    press_judge(4'b0001, 0, 1'b1);
    chk("sat_score0_lit", dut_score(0), 255);
    chk("over_lit", int'(bus.game_over), 1);
    chk("over_wp_lit", int'(bus.win_player), 0);
    // OVER ignores round_start and presses.
    round_open(1'b0);
    @(negedge clk); bus.press = 4'b0010;
    no_judge(4, "over_press");
    chk("over_score1", dut_score(1), m_sc[1]);
    chk("over_sticky", int'(bus.game_over), 1);
    bus.press = '0;

    // Reset during the judge cycle: no score write, back to IDLE.
    do_reset();
    set_cards(8'b10_01_00_00, 12'b100_001_011_010, 4'hF, 8'd6);
    round_open(1'b1);
    bus.press = 4'b0100;
    @(negedge clk);
    chk("midjudge_valid", int'(bus.judge_valid), 1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midjudge");
    rst = 1'b1;
    bus.press = '0;
    @(negedge clk); bus.press = 4'b0100;
    no_judge(4, "after_reset_idle");
    bus.press = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bell_round_judge.md
# bell_round_judge

N-player judge for the bell-slap card game: latches the face-up cards of a round, arbitrates the first bell press, checks whether any colour totals exactly TARGET, and applies reward or penalty to per-player signed score registers. It also detects a winning margin. It sits between the keypad decoder (press lines) and the LCD/display controller (scores, judge result, game-over), replacing the fixed two-player press/right/score/win chain.

## Interface
- NUM_PLAYERS, 4: players, bells and face-up card slots (2..8)
- NUM_COLORS, 4: card colours; CW = clog2(NUM_COLORS)
- COUNT_W, 3: width of the symbol count on one card
- SCORE_W, 9: signed two's-complement score width
- TARGET, 5: colour total that makes a press right
- MARGIN, 50: lead required to win
- PENALTY, 1: transfer per opponent on a wrong press
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- round_start  in  1  one-cycle pulse; new cards are on card_* inputs
- card_valid  in  NUM_PLAYERS  slot holds a face-up card
- card_color  in  NUM_PLAYERS*CW  colour per slot
- card_count  in  NUM_PLAYERS*COUNT_W  symbol count per slot
- pot  in  8  reward for a right press, unsigned
- press  in  NUM_PLAYERS  bell level per player
- armed  out  1  round open for presses
- judge_valid  out  1  one-cycle result strobe
- judge_who  out  clog2(NUM_PLAYERS)  arbitrated presser
- judge_right  out  1  press was right
- score  out  NUM_PLAYERS*SCORE_W  signed scores, player i at [i*SCORE_W +: SCORE_W]
- game_over  out  1  sticky winner flag
- win_player  out  clog2(NUM_PLAYERS)  winner index, valid when game_over is high

## Operation
- FSM states: IDLE, ARMED, JUDGE, OVER.
- IDLE: on round_start, latch the card_* inputs and go to ARMED.
- ARMED: a round_start pulse re-latches the cards and the FSM stays in ARMED. A press rising edge on any player registers the arbitrated presser and the right flag, then the FSM goes to JUDGE.
- JUDGE: lasts one cycle. judge_valid is high and the scores are written. Next state is OVER if the win check fires on the new scores, otherwise IDLE.
- OVER: all inputs are ignored until reset.
- Press edge detection: a registered copy of press is kept in every state. Only a 0→1 transition during ARMED counts. A held press never re-triggers a judge.
- Right check: for each colour c, sum card_count over slots with card_valid set and a matching colour. The sum is COUNT_W + clog2(NUM_PLAYERS) bits wide, with no overflow. The press is right if any sum equals TARGET. If no cards are valid, every sum is 0 and the press is wrong.
- Right press: presser score += pot, zero-extended. Other scores are unchanged.
- Wrong press: presser score −= (NUM_PLAYERS−1)*PENALTY. Every other player gains PENALTY.
- All score arithmetic saturates at the signed range, +2^(SCORE_W−1)−1 and −2^(SCORE_W−1).
- Win check: some player i has score_i ≥ score_j + MARGIN for every j ≠ i. Compare in SCORE_W+1 bits to avoid wrap. The lowest qualifying index wins.
- Presses arriving in IDLE, JUDGE or OVER are ignored. round_start arriving in JUDGE or OVER is ignored.

## Timing
- Reset values: all scores 0, armed=0, judge_valid=0, judge_who=0, judge_right=0, game_over=0, win_player=0. State is IDLE and the press-history register is 0.
- Reset mid-round or mid-JUDGE aborts the round with no score write.
- round_start at cycle t: armed=1 from t+1.
- Press edge seen at cycle t: judge_valid, judge_who and judge_right are high/valid in t+1; armed=0 in t+1.
- Updated scores are visible from t+2. game_over, if the win check fires, is high from t+2.
- One judge per round; a new round_start is required after JUDGE.

## Configuration
- BELL_RR_PRIORITY_EN defined: simultaneous press edges are resolved round-robin. Search starts at (last judge_who + 1) mod NUM_PLAYERS. The pointer resets to player 0, meaning the search starts at player 0 after reset.
- BELL_RR_PRIORITY_EN undefined: fixed priority; the lowest index wins.

## Structure
- Shared package bell_pkg holds: the FSM state enum, the saturating signed add function, and the default TARGET/MARGIN constants.
- One natural sub-module, bell_press_arbiter: edge detection plus fixed or round-robin pick. Its outputs are a hit flag and a winner index.
- Colour summation, the score file and the win check stay in the top level.

## Test plan
- Colour sum exactly TARGET, right press: cards P0 colour0/2, P1 colour0/3, P2 colour1/1, P3 colour2/4; pot=6; round_start, then press[2] rises. Expect judge_who=2, judge_right=1, score2=6, others 0.
- Colour sum misses TARGET, wrong press: cards P0 colour0/2, P1 colour0/4, P2 colour1/1, P3 colour2/4; press[1]. Expect judge_right=0, score1=−3, score0=score2=score3=+1.
- Simultaneous presses: press[1] and press[3] rise in the same cycle, with the previous winner being 2. Macro off: expect who=1. Macro on: expect who=3.
- Held press and late press: press[0] stays high across two rounds. Expect exactly one judge. A press in IDLE gives no judge_valid.
- Saturation and margin: with SCORE_W=9, score0=250 and pot=10, a right press gives score0=255. game_over=1, win_player=0 from the next cycle, and later presses and round_starts are ignored.
- Reset mid-JUDGE: rst=0 in the judge_valid cycle. Expect no score change, all outputs at reset values, state IDLE.
